// File: rtl/input_control_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : input_control_multi_if
// Description : Bundle of the input_control_multi control pulses and status
//               outputs. The master modport is the pulse source (the user
//               input front end). The slave modport is the controller.
//               Ports (master view):
//                 out i_ena, i_wr_pulse, i_sel_inc_pulse, i_sel_dec_pulse,
//                     i_val_inc_pulse, i_val_dec_pulse
//                 in  o_wr_toggle, o_sel_val[SEL_W], o_sel_onehot[NUM_SEL],
//                     o_val_inc, o_val_dec, o_timeout
// Revision    : 1.0 - initial release
// ============================================================================
interface input_control_multi_if #(
    parameter int NUM_SEL = 4,
    parameter int SEL_W   = 2
);
    logic               i_ena;
    logic               i_wr_pulse;
    logic               i_sel_inc_pulse;
    logic               i_sel_dec_pulse;
    logic               i_val_inc_pulse;
    logic               i_val_dec_pulse;
    logic               o_wr_toggle;
    logic [SEL_W-1:0]   o_sel_val;
    logic [NUM_SEL-1:0] o_sel_onehot;
    logic               o_val_inc;
    logic               o_val_dec;
    logic               o_timeout;

    modport master (
        output i_ena, i_wr_pulse, i_sel_inc_pulse, i_sel_dec_pulse,
               i_val_inc_pulse, i_val_dec_pulse,
        input  o_wr_toggle, o_sel_val, o_sel_onehot, o_val_inc, o_val_dec,
               o_timeout
    );

    modport slave (
        input  i_ena, i_wr_pulse, i_sel_inc_pulse, i_sel_dec_pulse,
               i_val_inc_pulse, i_val_dec_pulse,
        output o_wr_toggle, o_sel_val, o_sel_onehot, o_val_inc, o_val_dec,
               o_timeout
    );
endinterface
`default_nettype wire

// File: rtl/input_control_multi.sv
`default_nettype none
// ============================================================================
// Module      : input_control_multi
// Description : Multi-field input controller. A write pulse toggles between
//               IDLE and EDIT. In EDIT, the sel pulses step a wrapping select
//               index. The val pulses become registered one-cycle adjust
//               pulses for the selected field. If TIMEOUT enabled cycles pass
//               with no activity, EDIT is left automatically and o_timeout
//               pulses.
//               Ports:
//                 i_clk     - clock, rising edge
//                 i_reset_n - asynchronous active-low reset
//                 bus       - input_control_multi_if.slave (pulses/status)
// Revision    : 1.0 - initial release
// ============================================================================
module input_control_multi #(
    parameter int NUM_SEL = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input_control_multi_if.slave  bus
);

    // A counter of this width can hold the value TIMEOUT. It is at least 1 bit.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(TIMEOUT);
    localparam logic [SEL_W-1:0] c_sel_max     = SEL_W'(NUM_SEL - 1);
    localparam logic             c_timeout_en  = (TIMEOUT > 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EDIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_idle_cnt;
    logic               r_val_inc;
    logic               r_val_dec;
    logic               r_timeout;
    logic [NUM_SEL-1:0] w_onehot;

    // If both directions arrive in the same cycle, they cancel. The cycle
    // still counts as activity.
    logic w_sel_inc_only;
    logic w_sel_dec_only;
    logic w_val_inc_only;
    logic w_val_dec_only;
    logic w_activity;

    assign w_sel_inc_only = bus.i_sel_inc_pulse & ~bus.i_sel_dec_pulse;
    assign w_sel_dec_only = bus.i_sel_dec_pulse & ~bus.i_sel_inc_pulse;
    assign w_val_inc_only = bus.i_val_inc_pulse & ~bus.i_val_dec_pulse;
    assign w_val_dec_only = bus.i_val_dec_pulse & ~bus.i_val_inc_pulse;
    assign w_activity     = bus.i_sel_inc_pulse | bus.i_sel_dec_pulse |
                            bus.i_val_inc_pulse | bus.i_val_dec_pulse;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_idle_cnt <= '0;
            r_val_inc  <= 1'b0;
            r_val_dec  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            // Output pulses always clear after one cycle. This holds even
            // when i_ena is low, so a pulse that is already scheduled still
            // completes.
            r_val_inc <= 1'b0;
            r_val_dec <= 1'b0;
            r_timeout <= 1'b0;
            if (bus.i_ena) begin
                if (bus.i_wr_pulse) begin
                    // A write pulse has priority over a timeout and over
                    // all sel and val pulses in the same cycle.
                    r_state    <= (r_state == S_IDLE) ? S_EDIT : S_IDLE;
                    r_sel      <= '0;
                    r_idle_cnt <= '0;
                end else if (r_state == S_EDIT) begin
                    if (c_timeout_en && (r_idle_cnt == c_timeout_cnt)) begin
                        r_state    <= S_IDLE;
                        r_sel      <= '0;
                        r_idle_cnt <= '0;
                        r_timeout  <= 1'b1;
                    end else if (w_activity) begin
                        r_idle_cnt <= '0;
                        if (w_sel_inc_only) begin
                            r_sel <= (r_sel == c_sel_max) ? '0 : r_sel + SEL_W'(1);
                        end else if (w_sel_dec_only) begin
                            r_sel <= (r_sel == '0) ? c_sel_max : r_sel - SEL_W'(1);
                        end
                        r_val_inc <= w_val_inc_only;
                        r_val_dec <= w_val_dec_only;
                    end else if (r_idle_cnt != '1) begin
                        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if ((r_state == S_EDIT) && (r_sel == SEL_W'(i))) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign bus.o_wr_toggle  = (r_state == S_EDIT);
    assign bus.o_sel_val    = r_sel;
    assign bus.o_sel_onehot = w_onehot;
    assign bus.o_val_inc    = r_val_inc;
    assign bus.o_val_dec    = r_val_dec;
    assign bus.o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_input_control_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_control_multi
// Description : Testbench for input_control_multi with NUM_SEL=3, SEL_W=2,
//               TIMEOUT=5. It drives directed vectors with hand-computed
//               expected outputs. A monitor compares these expectations
//               with the design outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_control_multi;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    input_control_multi_if #(.NUM_SEL(3), .SEL_W(2)) bus ();

    input_control_multi #(
        .NUM_SEL (3),
        .SEL_W   (2),
        .TIMEOUT (5)
    ) u_dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [8:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];

    // Observed output packed as {wr, sel[1:0], onehot[2:0], vi, vd, to}
    function automatic logic [8:0] observed();
        return {bus.o_wr_toggle, bus.o_sel_val, bus.o_sel_onehot,
                bus.o_val_inc, bus.o_val_dec, bus.o_timeout};
    endfunction

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {wr,sel,oh,vi,vd,to}=%b want %b", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the output expected after the edge.
    task automatic step(input logic ena, input logic wr, input logic si, input logic sd,
                        input logic vi, input logic vd,
                        input logic ewr, input logic [1:0] esel, input logic [2:0] eoh,
                        input logic evi, input logic evd, input logic eto,
                        input string nm);
        exp_t e;
        @(negedge clk);
        bus.i_ena           = ena;
        bus.i_wr_pulse      = wr;
        bus.i_sel_inc_pulse = si;
        bus.i_sel_dec_pulse = sd;
        bus.i_val_inc_pulse = vi;
        bus.i_val_dec_pulse = vd;
        e.exp  = {ewr, esel, eoh, evi, evd, eto};
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic idle_n(input int n, input logic [1:0] esel, input logic [2:0] eoh, input string nm);
        for (int k = 0; k < n; k++) step(1,0,0,0,0,0, 1,esel,eoh,0,0,0, nm);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
    endtask

    // Monitor: the outputs settle after each active edge, so compare then.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, observed(), e.exp);
            end
        end
    end

    initial begin
        bus.i_ena = 1'b1;
        bus.i_wr_pulse = 1'b0;
        bus.i_sel_inc_pulse = 1'b0;
        bus.i_sel_dec_pulse = 1'b0;
        bus.i_val_inc_pulse = 1'b0;
        bus.i_val_dec_pulse = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", observed(), 9'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //    ena wr si sd vi vd | wr sel oh     vi vd to
        step(1,0,0,0,1,0, 0,2'd0,3'b000,0,0,0, "idle_val_inc_ignored");
        step(1,0,1,0,0,0, 0,2'd0,3'b000,0,0,0, "idle_sel_inc_ignored");
        step(1,1,0,0,0,0, 1,2'd0,3'b001,0,0,0, "enter_edit");
        step(1,0,1,0,0,0, 1,2'd1,3'b010,0,0,0, "sel_inc_1");
        step(1,0,1,0,0,0, 1,2'd2,3'b100,0,0,0, "sel_inc_2");
        step(1,0,1,0,0,0, 1,2'd0,3'b001,0,0,0, "sel_inc_wrap");
        step(1,0,1,0,0,0, 1,2'd1,3'b010,0,0,0, "sel_inc_1b");
        step(1,0,0,1,0,0, 1,2'd0,3'b001,0,0,0, "sel_dec_0");
        step(1,0,0,1,0,0, 1,2'd2,3'b100,0,0,0, "sel_dec_wrap");
        step(1,0,1,1,0,0, 1,2'd2,3'b100,0,0,0, "sel_both_hold");
        step(1,0,0,0,1,0, 1,2'd2,3'b100,1,0,0, "val_inc_pulse");
        step(1,0,0,0,0,0, 1,2'd2,3'b100,0,0,0, "val_inc_one_cycle");
        step(1,0,0,0,1,1, 1,2'd2,3'b100,0,0,0, "val_both_none");
        step(1,0,0,0,0,1, 1,2'd2,3'b100,0,1,0, "val_dec_pulse");
        step(1,0,1,0,1,0, 1,2'd0,3'b001,1,0,0, "sel_and_val");
        step(1,1,1,0,1,0, 0,2'd0,3'b000,0,0,0, "exit_ignores_pulses");

        // Timeout after five idle enabled cycles
        step(1,1,0,0,0,0, 1,2'd0,3'b001,0,0,0, "reenter");
        step(1,0,1,0,0,0, 1,2'd1,3'b010,0,0,0, "to_sel1");
        step(1,0,1,0,0,0, 1,2'd2,3'b100,0,0,0, "to_sel2");
        idle_n(5, 2'd2, 3'b100, "to_idle_wait");
        step(1,0,0,0,0,0, 0,2'd0,3'b000,0,0,1, "timeout_fire");
        step(1,0,0,0,0,0, 0,2'd0,3'b000,0,0,0, "timeout_one_cycle");

        // Activity at idle cycle 4 restarts the count
        step(1,1,0,0,0,0, 1,2'd0,3'b001,0,0,0, "enter_b");
        step(1,0,1,0,0,0, 1,2'd1,3'b010,0,0,0, "b_sel1");
        step(1,0,1,0,0,0, 1,2'd2,3'b100,0,0,0, "b_sel2");
        idle_n(3, 2'd2, 3'b100, "b_idle_pre");
        step(1,0,1,0,0,0, 1,2'd0,3'b001,0,0,0, "b_sel_at_idle4");
        idle_n(5, 2'd0, 3'b001, "b_no_early_timeout");
        step(1,0,0,0,0,0, 0,2'd0,3'b000,0,0,1, "b_timeout_fire");

        // A write pulse coinciding with a timeout wins
        step(1,1,0,0,0,0, 1,2'd0,3'b001,0,0,0, "enter_c");
        idle_n(5, 2'd0, 3'b001, "c_idle");
        step(1,1,0,0,0,0, 0,2'd0,3'b000,0,0,0, "wr_beats_timeout");
        step(1,0,0,0,0,0, 0,2'd0,3'b000,0,0,0, "no_reenter");

        // i_ena low freezes everything except a pending pulse's completion
        step(1,1,0,0,0,0, 1,2'd0,3'b001,0,0,0, "enter_d");
        step(1,0,1,0,0,0, 1,2'd1,3'b010,0,0,0, "d_sel1");
        step(1,0,0,0,1,0, 1,2'd1,3'b010,1,0,0, "d_val_inc");
        step(0,0,1,0,0,0, 1,2'd1,3'b010,0,0,0, "ena0_pulse_completes");
        step(0,1,0,0,0,0, 1,2'd1,3'b010,0,0,0, "ena0_wr_ignored");
        step(0,0,0,1,0,0, 1,2'd1,3'b010,0,0,0, "ena0_sd_ignored");
        step(0,0,0,0,1,0, 1,2'd1,3'b010,0,0,0, "ena0_vi_ignored");
        step(0,0,0,0,0,1, 1,2'd1,3'b010,0,0,0, "ena0_vd_ignored");
        step(0,0,0,0,0,0, 1,2'd1,3'b010,0,0,0, "ena0_hold5");
        step(0,0,0,0,0,0, 1,2'd1,3'b010,0,0,0, "ena0_hold6");
        step(0,0,0,0,0,0, 1,2'd1,3'b010,0,0,0, "ena0_hold7");
        step(0,0,1,0,0,0, 1,2'd1,3'b010,0,0,0, "ena0_hold8");
        step(0,0,0,0,0,0, 1,2'd1,3'b010,0,0,0, "ena0_hold9");
        idle_n(5, 2'd1, 3'b010, "d_counter_frozen");
        step(1,0,0,0,0,0, 0,2'd0,3'b000,0,0,1, "d_timeout_fire");

        // Asynchronous reset in the middle of EDIT
        step(1,1,0,0,0,0, 1,2'd0,3'b001,0,0,0, "enter_e");
        step(1,0,1,0,0,0, 1,2'd1,3'b010,0,0,0, "e_sel1");
        step(1,0,1,0,0,0, 1,2'd2,3'b100,0,0,0, "e_sel2");
        drain();
        bus.i_sel_inc_pulse = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("async_reset_immediate", observed(), 9'b0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", observed(), 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1,0,0,0,0,0, 0,2'd0,3'b000,0,0,0, "post_reset_idle");
        step(1,1,0,0,0,0, 1,2'd0,3'b001,0,0,0, "post_reset_enter");
        step(1,0,0,1,0,0, 1,2'd2,3'b100,0,0,0, "post_reset_dec");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
